// File: rtl/stream_arb2_pkg.sv
// stream_arb2 shared types and constants.
// Source encoding, default parameters, counter width helper.
package stream_arb2_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_BURST = 4;

  function automatic int cnt_w(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/stream_arb2_mux.sv
// WIDTH-bit 2:1 combinational data mux.
// Ports: y out, a (s=0) in, b (s=1) in, s select.
module mux2_bus #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s
);

  assign y = s ? b : a;

endmodule

// File: rtl/stream_arb2.sv
// Two-source round-robin stream arbiter, burst limit, registered out.
// Ports: clk, n_reset, a_/b_ valid/data/ready, y_ valid/data/src/ready.
module stream_arb2
  import stream_arb2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BURST = DEF_BURST
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_src,
  input  logic             y_ready
);

  localparam int CW = cnt_w(BURST);
  localparam logic [CW-1:0] CMAX = CW'(BURST);
  localparam logic [CW-1:0] CONE = CW'(1);

  src_t             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             yv_q;
  logic [WIDTH-1:0] yd_q;
  src_t             ys_q;

  src_t             grant;
  logic             out_free;
  logic             xfer;
  logic [WIDTH-1:0] mux_y;

  assign out_free = !yv_q || y_ready;

  // Contention: owner keeps the bus until it has used its burst.
  always_comb begin
    grant = owner_q;
    unique case (1'b1)
      a_valid && !b_valid: grant = SRC_A;
      !a_valid && b_valid: grant = SRC_B;
      a_valid && b_valid:
        grant = (cnt_q < CMAX) ? owner_q
                               : src_t'(~owner_q);
      default: grant = owner_q;
    endcase
  end

  assign a_ready = out_free && (grant == SRC_A);
  assign b_ready = out_free && (grant == SRC_B);
  assign xfer    = (a_valid && a_ready) ||
                   (b_valid && b_ready);

  mux2_bus #(
    .WIDTH(WIDTH)
  ) u_mux (
    .y(mux_y),
    .a(a_data),
    .b(b_data),
    .s(grant)
  );

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      if (grant == owner_q) begin
        cnt_d = (cnt_q == CMAX) ? cnt_q
                                : cnt_q + CONE;
      end else begin
        owner_d = grant;
        cnt_d   = CONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      owner_q <= SRC_A;
      cnt_q   <= '0;
      yv_q    <= 1'b0;
      yd_q    <= '0;
      ys_q    <= SRC_A;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      if (out_free) begin
        yv_q <= xfer;
        if (xfer) begin
          yd_q <= mux_y;
          ys_q <= grant;
        end
      end
    end
  end

  assign y_valid = yv_q;
  assign y_data  = yd_q;
  assign y_src   = ys_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Self-checking bench for stream_arb2.
// Directed table, corner sequences, random vs reference model.
module tb_stream_arb2;

  localparam int W = 8;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         a_valid, b_valid, y_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready;
  logic         y_valid, y_src;
  logic [W-1:0] y_data;

  stream_arb2 #(
    .WIDTH(W),
    .BURST(B)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .a_valid(a_valid),
    .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data(b_data),
    .b_ready(b_ready),
    .y_valid(y_valid),
    .y_data(y_data),
    .y_src(y_src),
    .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference: who last won and how many in a row.
  bit       last_m;
  int       run_m;
  bit       yv_m;
  bit [W-1:0] yd_m;
  bit       ys_m;
  bit       acc_a, acc_b;

  typedef struct {
    bit         src;
    bit [W-1:0] data;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  function automatic bit pick();
    if (a_valid && !b_valid) return 1'b0;
    if (b_valid && !a_valid) return 1'b1;
    if (!a_valid && !b_valid) return last_m;
    return (run_m < B) ? last_m : !last_m;
  endfunction

  task automatic model_reset();
    last_m = 1'b0;
    run_m  = 0;
    yv_m   = 1'b0;
    yd_m   = '0;
    ys_m   = 1'b0;
  endtask

  task automatic cycle();
    bit g, free, x;
    #1;
    g    = pick();
    free = !yv_m || y_ready;
    x    = free && (g ? b_valid : a_valid);
    chk("a_ready", 32'(a_ready), 32'(free && !g));
    chk("b_ready", 32'(b_ready), 32'(free && g));
    acc_a = x && !g;
    acc_b = x && g;
    @(posedge clk);
    if (free) begin
      yv_m = x;
      if (x) begin
        yd_m = g ? b_data : a_data;
        ys_m = g;
      end
    end
    if (x) begin
      if (g == last_m) run_m = (run_m < B) ? run_m + 1 : B;
      else begin
        last_m = g;
        run_m  = 1;
      end
    end
    #1;
    chk("y_valid", 32'(y_valid), 32'(yv_m));
    if (yv_m) chk("y_data", 32'(y_data), 32'(yd_m));
    if (yv_m) chk("y_src", 32'(y_src), 32'(ys_m));
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    y_ready = 1'b1;
    a_data  = '0;
    b_data  = '0;
    model_reset();
    #1;
    chk("rst y_valid", 32'(y_valid), 32'd0);
    chk("rst y_data", 32'(y_data), 32'd0);
    chk("rst y_src", 32'(y_src), 32'd0);
    chk("rst a_ready", 32'(a_ready), 32'd1);
    chk("rst b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  initial begin
    int na, nb;
    bit [W-1:0] wa [3];
    for (int i = 0; i < 4; i++) begin
      tv[i]   = '{1'b0, 8'(8'hA0 + i)};
      tv[i+4] = '{1'b1, 8'(8'hB0 + i)};
      tv[i+8] = '{1'b0, 8'(8'hA4 + i)};
    end
    wa[0] = 8'h11;
    wa[1] = 8'h22;
    wa[2] = 8'h33;

    do_reset();

    // Lone source A
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a_data  = wa[i];
      cycle();
      chk("single data", 32'(y_data), 32'(wa[i]));
      chk("single src", 32'(y_src), 32'd0);
      chk("single b_ready", 32'(b_ready), 32'd0);
    end

    // Contention with burst limit
    do_reset();
    na = 0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      a_valid = 1'b1;
      b_valid = 1'b1;
      y_ready = 1'b1;
      a_data  = 8'(8'hA0 + na);
      b_data  = 8'(8'hB0 + nb);
      cycle();
      chk("rr valid", 32'(y_valid), 32'd1);
      chk("rr src", 32'(y_src), 32'(tv[i].src));
      chk("rr data", 32'(y_data), 32'(tv[i].data));
      if (acc_a) na++;
      if (acc_b) nb++;
    end

    // Backpressure
    b_valid = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'h5A;
    cycle();
    y_ready = 1'b0;
    a_data  = 8'h66;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp hold", 32'(y_data), 32'h5A);
      chk("bp a_ready", 32'(a_ready), 32'd0);
      chk("bp b_ready", 32'(b_ready), 32'd0);
    end
    y_ready = 1'b1;
    cycle();
    chk("bp release", 32'(y_data), 32'h66);

    // Early switch to B
    a_data = 8'h01;
    cycle();
    a_data = 8'h02;
    cycle();
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_data  = 8'hC1;
    cycle();
    chk("early src", 32'(y_src), 32'd1);
    chk("early data", 32'(y_data), 32'hC1);
    a_valid = 1'b1;
    a_data  = 8'h03;
    b_data  = 8'hC2;
    cycle();
    chk("B keeps", 32'(y_src), 32'd1);

    // Reset mid-burst
    b_valid = 1'b0;
    a_data  = 8'h04;
    cycle();
    a_data  = 8'h05;
    cycle();
    a_valid = 1'b0;
    y_ready = 1'b0;
    @(posedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    model_reset();
    chk("mid rst y_valid", 32'(y_valid), 32'd0);
    chk("mid rst a_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    n_reset = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    y_ready = 1'b1;
    a_data  = 8'h77;
    b_data  = 8'h88;
    cycle();
    chk("post rst A", 32'(y_src), 32'd0);
    chk("post rst data", 32'(y_data), 32'h77);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      y_ready = ($urandom_range(0, 3) != 0);
      a_data  = 8'($urandom);
      b_data  = 8'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
